// File: rtl/mem_stage.sv
// Memory-access pipeline stage: request/acknowledge handshake with the data memory,
// EX/MEM stall generation and writeback bubbles. Optional access timeout: MEM_TIMEOUT_EN.
module mem_stage #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clockIn,
    input  logic        reset,
    input  logic        haltIn,
    input  logic        regWriteIn,
    input  logic        mem2RegIn,
    input  logic        memReadIn,
    input  logic        memWriteIn,
    input  logic [31:0] data1In,
    input  logic [31:0] data2In,
    input  logic [4:0]  regIn,
    output logic        memStall,
    output logic        memReq,
    output logic        memWe,
    output logic [31:0] memAddr,
    output logic [31:0] memWdata,
    input  logic        memAck,
    input  logic [31:0] memRdata,
    output logic        haltOut,
    output logic        regWriteOut,
    output logic        mem2RegOut,
    output logic [31:0] aluOut,
    output logic [31:0] memDataOut,
    output logic [4:0]  regOut,
    output logic        memErr
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic        acc;
    logic        abort;
    logic [31:0] rdataReg;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("mem_stage: TIMEOUT_CYCLES must be within 1..255");
    end

    assign acc = memReadIn | memWriteIn;

`ifdef MEM_TIMEOUT_EN
    localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT_CYCLES);

    logic [7:0] tmo_cnt;
    logic       err_q;

    // Abort on the BUSY cycle that would bring the count to the limit; an ack that same cycle wins.
    assign abort  = (state == BUSY) & ~memAck & ((tmo_cnt + 8'd1) == TMO_LIMIT);
    assign memErr = err_q;

    always_ff @(posedge clockIn) begin
        if (reset) begin
            tmo_cnt <= 8'd0;
            err_q   <= 1'b0;
        end else begin
            if (state == IDLE && acc)
                tmo_cnt <= 8'd0;
            else if (state == BUSY && !memAck)
                tmo_cnt <= tmo_cnt + 8'd1;
            if (abort)
                err_q <= 1'b1;
        end
    end
`else
    assign abort  = 1'b0;
    assign memErr = 1'b0;
`endif

    always_ff @(posedge clockIn) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (acc) state_next = BUSY;
            BUSY:    if (memAck || abort) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Request registers are loaded once on entry to BUSY and held until completion.
    always_ff @(posedge clockIn) begin
        if (reset) begin
            memReq   <= 1'b0;
            memWe    <= 1'b0;
            memAddr  <= 32'd0;
            memWdata <= 32'd0;
            rdataReg <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (acc) begin
                        memReq   <= 1'b1;
                        memAddr  <= data1In;
                        memWdata <= data2In;
                        memWe    <= memWriteIn;
                    end
                end
                BUSY: begin
                    if (memAck) begin
                        memReq   <= 1'b0;
                        rdataReg <= memRdata;
                    end else if (abort) begin
                        memReq   <= 1'b0;
                        rdataReg <= 32'hDEADBEEF;
                    end
                end
                default: ;
            endcase
        end
    end

    assign memStall = ((state == IDLE) & acc) | (state == BUSY);

    // Writeback side: bubbles are inserted by masking the state-changing control bits.
    assign aluOut      = data1In;
    assign regOut      = regIn;
    assign mem2RegOut  = mem2RegIn;
    assign memDataOut  = rdataReg;
    assign regWriteOut = regWriteIn & ~memStall;
    assign haltOut     = haltIn & ~memStall;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: vector table for passthrough ops, scoreboarded memory accesses.
module tb_mem_stage;

    logic        clockIn = 1'b0;
    logic        reset;
    logic        haltIn, regWriteIn, mem2RegIn, memReadIn, memWriteIn;
    logic [31:0] data1In, data2In;
    logic [4:0]  regIn;
    logic        memStall, memReq, memWe;
    logic [31:0] memAddr, memWdata;
    logic        memAck;
    logic [31:0] memRdata;
    logic        haltOut, regWriteOut, mem2RegOut;
    logic [31:0] aluOut, memDataOut;
    logic [4:0]  regOut;
    logic        memErr;

    int total = 0;
    int bad   = 0;

    mem_stage #(.TIMEOUT_CYCLES(4)) dut (
        .clockIn(clockIn), .reset(reset),
        .haltIn(haltIn), .regWriteIn(regWriteIn), .mem2RegIn(mem2RegIn),
        .memReadIn(memReadIn), .memWriteIn(memWriteIn),
        .data1In(data1In), .data2In(data2In), .regIn(regIn),
        .memStall(memStall), .memReq(memReq), .memWe(memWe),
        .memAddr(memAddr), .memWdata(memWdata),
        .memAck(memAck), .memRdata(memRdata),
        .haltOut(haltOut), .regWriteOut(regWriteOut), .mem2RegOut(mem2RegOut),
        .aluOut(aluOut), .memDataOut(memDataOut), .regOut(regOut),
        .memErr(memErr)
    );

    always #5 clockIn = ~clockIn;

    logic req_q = 1'b0;
    int   rises = 0;
    always @(posedge clockIn) begin
        req_q <= memReq;
        if (memReq && !req_q) rises <= rises + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time=%0t required=<200000", $time);
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic        halt, rw, m2r;
        logic [31:0] d1;
        logic [4:0]  rg;
        logic        exp_halt, exp_rw, exp_m2r;
        logic [31:0] exp_alu;
        logic [4:0]  exp_reg;
    } vec_t;

    typedef struct {
        logic [31:0] addr, wdata, rdata;
        logic        we;
    } exp_t;

    exp_t sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clockIn);
        #2;
    endtask

    task automatic clear_inputs();
        haltIn = 0; regWriteIn = 0; mem2RegIn = 0; memReadIn = 0; memWriteIn = 0;
        data1In = 0; data2In = 0; regIn = 0; memAck = 0; memRdata = 0;
    endtask

    // One access with ack k cycles after memReq rises; optional stray ack in the IDLE cycle.
    task automatic access(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] rdata,
                          input int k, input logic idle_ack);
        exp_t e;
        memReadIn = rd; memWriteIn = wr; regWriteIn = 1; mem2RegIn = rd;
        regIn = 5'd9; haltIn = 0; data1In = addr; data2In = wdata;
        memAck = idle_ack; memRdata = idle_ack ? 32'h11111111 : 32'h0;
        sb.push_back('{addr: addr, wdata: wdata, rdata: rdata, we: wr});
        for (int c = 0; c <= 2 + k; c++) begin
            if (c > 0) begin
                next_cycle();
                memAck   = (c == 1 + k);
                memRdata = (c == 1 + k) ? rdata : 32'h0;
            end
            @(negedge clockIn);
            chk("acc_stall", memStall, (c <= 1 + k));
            chk("acc_req", memReq, (c >= 1 && c <= 1 + k));
            chk("acc_regwrite", regWriteOut, (c == 2 + k));
            if (c == 1) begin
                chk("acc_addr", memAddr, sb[0].addr);
                chk("acc_we", memWe, sb[0].we);
                chk("acc_wdata", memWdata, sb[0].wdata);
            end
            if (c == 2 + k) begin
                e = sb.pop_front();
                chk("acc_rdata", memDataOut, e.rdata);
            end
        end
        next_cycle();
        clear_inputs();
    endtask

    vec_t vecs[4];

    initial begin
        int base;
        vecs[0] = '{halt:0, rw:1, m2r:0, d1:32'h10,       rg:5'd5,
                    exp_halt:0, exp_rw:1, exp_m2r:0, exp_alu:32'h10,       exp_reg:5'd5};
        vecs[1] = '{halt:1, rw:0, m2r:1, d1:32'hFFFFFFFF, rg:5'd31,
                    exp_halt:1, exp_rw:0, exp_m2r:1, exp_alu:32'hFFFFFFFF, exp_reg:5'd31};
        vecs[2] = '{halt:0, rw:0, m2r:0, d1:32'h0,        rg:5'd0,
                    exp_halt:0, exp_rw:0, exp_m2r:0, exp_alu:32'h0,        exp_reg:5'd0};
        vecs[3] = '{halt:1, rw:1, m2r:1, d1:32'h12345678, rg:5'd17,
                    exp_halt:1, exp_rw:1, exp_m2r:1, exp_alu:32'h12345678, exp_reg:5'd17};

        reset = 1;
        clear_inputs();
        repeat (2) @(posedge clockIn);
        #2;
        reset = 0;
        @(negedge clockIn);
        chk("rst_req", memReq, 0);
        chk("rst_we", memWe, 0);
        chk("rst_addr", memAddr, 0);
        chk("rst_wdata", memWdata, 0);
        chk("rst_rdata", memDataOut, 0);
        chk("rst_err", memErr, 0);
        chk("rst_stall", memStall, 0);
        next_cycle();

        for (int i = 0; i < 4; i++) begin
            haltIn = vecs[i].halt; regWriteIn = vecs[i].rw; mem2RegIn = vecs[i].m2r;
            data1In = vecs[i].d1; regIn = vecs[i].rg;
            @(negedge clockIn);
            chk("vec_stall", memStall, 0);
            chk("vec_halt", haltOut, vecs[i].exp_halt);
            chk("vec_regwrite", regWriteOut, vecs[i].exp_rw);
            chk("vec_mem2reg", mem2RegOut, vecs[i].exp_m2r);
            chk("vec_alu", aluOut, vecs[i].exp_alu);
            chk("vec_reg", regOut, vecs[i].exp_reg);
            chk("vec_req", memReq, 0);
            next_cycle();
        end
        clear_inputs();

        access(1, 0, 32'h100, 32'h0, 32'hCAFEF00D, 2, 0);
        access(1, 1, 32'h200, 32'h55AA, 32'h0BADF00D, 0, 0);

        base = rises;
        access(1, 0, 32'h300, 32'h0, 32'hA5A5A5A5, 1, 0);
        memAck = 1; memRdata = 32'h77777777;
        @(negedge clockIn);
        chk("idle_ack_stall", memStall, 0);
        next_cycle();
        memAck = 0;
        @(negedge clockIn);
        chk("idle_ack_rdata", memDataOut, 32'hA5A5A5A5);
        chk("idle_ack_req", memReq, 0);
        next_cycle();
        access(1, 0, 32'h304, 32'h0, 32'h5A5A5A5A, 1, 1);
        chk("req_pulses", rises - base, 2);

        memReadIn = 1; regWriteIn = 1; data1In = 32'h400;
        sb.push_back('{addr: 32'h400, wdata: 32'h0, rdata: 32'h0, we: 1'b0});
        next_cycle();
        @(negedge clockIn);
        chk("rb_busy_req", memReq, 1);
        reset = 1;
        next_cycle();
        reset = 0;
        clear_inputs();
        memAck = 1; memRdata = 32'h99999999;
        void'(sb.pop_front());
        @(negedge clockIn);
        chk("rb_req", memReq, 0);
        chk("rb_stall", memStall, 0);
        next_cycle();
        memAck = 0;
        @(negedge clockIn);
        chk("rb_rdata", memDataOut, 0);
        chk("rb_req2", memReq, 0);
        chk("rb_stall2", memStall, 0);
        next_cycle();

        memReadIn = 1; regWriteIn = 1; data1In = 32'h500;
`ifdef MEM_TIMEOUT_EN
        for (int c = 0; c <= 5; c++) begin
            if (c > 0) next_cycle();
            @(negedge clockIn);
            chk("tmo_req", memReq, (c >= 1 && c <= 4));
            chk("tmo_stall", memStall, (c <= 4));
        end
        chk("tmo_rdata", memDataOut, 32'hDEADBEEF);
        chk("tmo_err", memErr, 1);
        next_cycle();
        clear_inputs();
        repeat (3) next_cycle();
        @(negedge clockIn);
        chk("tmo_err_sticky", memErr, 1);
`else
        for (int c = 0; c < 300; c++) begin
            if (c > 0) next_cycle();
            @(negedge clockIn);
            chk("notmo_stall", memStall, 1);
            chk("notmo_err", memErr, 0);
        end
        chk("notmo_req", memReq, 1);
`endif
        next_cycle();
        reset = 1;
        clear_inputs();
        next_cycle();
        reset = 0;
        @(negedge clockIn);
        chk("final_err", memErr, 0);
        chk("final_req", memReq, 0);
        chk("final_stall", memStall, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage between the EX/MEM pipeline buffer and the MEM/WB buffer. It decodes the buffered memory-control bits and runs a request/acknowledge handshake with the data-memory port. It drives `memStall` back to the EX/MEM buffer, which holds its contents until the access completes. It also presents writeback fields (ALU result, load data, destination register, control bits) to the MEM/WB buffer, inserting bubbles while stalled.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 255: BUSY cycles without `memAck` before abort. Used only with `MEM_TIMEOUT_EN`; range 1..255.

Ports:
- `clockIn` in 1: sole clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `haltIn`, `regWriteIn`, `mem2RegIn`, `memReadIn`, `memWriteIn` in 1 each: control bits from the EX/MEM buffer.
- `data1In` in 32: ALU result / memory byte address.
- `data2In` in 32: store data.
- `regIn` in 5: destination register.
- `memStall` out 1: holds the EX/MEM buffer.
- `memReq` out 1: memory request, registered.
- `memWe` out 1: 1 = write, 0 = read, registered.
- `memAddr` out 32: registered.
- `memWdata` out 32: registered.
- `memAck` in 1: memory completion, sampled only in BUSY.
- `memRdata` in 32: read data, valid with `memAck`.
- `haltOut`, `regWriteOut`, `mem2RegOut` out 1 each: to MEM/WB.
- `aluOut` out 32: `data1In` passthrough.
- `memDataOut` out 32: captured load data.
- `regOut` out 5: `regIn` passthrough.
- `memErr` out 1: sticky timeout error.

## Operation
- Access pending: `acc = memReadIn | memWriteIn`.
- FSM has 2-bit state: IDLE, BUSY, DONE.
- IDLE:
  - If `acc`: next state BUSY. Load `memReq<=1`, `memAddr<=data1In`, `memWdata<=data2In`, `memWe<=memWriteIn`.
  - Otherwise stay in IDLE.
- BUSY:
  - Hold all request registers.
  - On `memAck`: `memReq<=0`, capture `rdataReg<=memRdata` (also on writes), go to DONE.
- DONE: unconditionally go to IDLE. The EX/MEM buffer advances at this edge.
- `memStall` is combinational: `(state==IDLE & acc) | state==BUSY`. It is 0 in DONE and in IDLE with no access.
- Writeback outputs:
  - `aluOut`, `regOut`, `mem2RegOut` pass straight through from the inputs.
  - `memDataOut = rdataReg`.
  - `regWriteOut = regWriteIn & ~memStall` and `haltOut = haltIn & ~memStall`, so MEM/WB captures bubbles during a stall.
- Read and write both asserted: treat as a write (`memWe=1`); `memDataOut` still shows the captured `memRdata`.
- `memAck` in IDLE or DONE is ignored.
- Non-memory instructions pass through in zero extra cycles.

## Timing
- Reset values: state IDLE; `memReq`, `memWe` = 0; `memAddr`, `memWdata`, `rdataReg` = 0; `memErr` = 0; timeout counter = 0. Passthrough outputs follow the inputs.
- Load or store, ack arriving k cycles after `memReq` rises (k ≥ 0):
  - Cycle 0: access appears, IDLE, stall=1.
  - Cycle 1: BUSY, `memReq`=1.
  - Cycle 1+k: ack sampled.
  - Cycle 2+k: DONE, stall=0.
  - Total occupancy is 3+k cycles; minimum 3 (ack in the same cycle `memReq` rises).
- Back-to-back accesses: the next instruction appears in IDLE the cycle after DONE and restarts the sequence. `memReq` is low for at least 2 cycles between requests.
- Reset in BUSY: `memReq` drops the next edge and any in-flight ack is discarded. The memory side must tolerate an abandoned request.

## Configuration
- `MEM_TIMEOUT_EN` defined:
  - An 8-bit counter clears on IDLE→BUSY and increments each BUSY cycle without `memAck`.
  - When it reaches `TIMEOUT_CYCLES`: `memReq<=0`, `rdataReg<=32'hDEADBEEF`, `memErr<=1` (sticky until reset), go to DONE.
  - `memAck` in that same cycle wins: normal completion, no error.
- `MEM_TIMEOUT_EN` undefined: no counter, BUSY waits indefinitely, `memErr` is tied 0.

## Test plan
- Reset, then ALU op (`regWriteIn=1`, `data1In=32'h10`, `regIn=5`) → `memStall` 0 throughout; same cycle `regWriteOut=1`, `aluOut=32'h10`, `regOut=5`.
- Load with `data1In=32'h100`, `memAck` 2 cycles after `memReq` with `memRdata=32'hCAFEF00D`:
  - `memReq=1`, `memWe=0`, `memAddr=32'h100` for cycles 1–3.
  - `memStall` 1 for cycles 0–3, 0 in cycle 4.
  - `memDataOut=32'hCAFEF00D` in cycle 4.
  - `regWriteOut` 0 in cycles 0–3, 1 in cycle 4.
- Store `data2In=32'h55AA`, both read and write bits set, immediate ack → `memWe=1`, `memWdata=32'h55AA`; stall lasts exactly 2 cycles.
- Two consecutive loads → two distinct `memReq` pulses, with `memReq` low ≥ 2 cycles between them; `memAck` injected during IDLE has no effect.
- Assert `reset` while in BUSY, then ack the next cycle → `memReq` 0, state IDLE, `memStall` follows only the inputs, `memDataOut` 0.
- With `MEM_TIMEOUT_EN` and `TIMEOUT_CYCLES=4`, load with no ack → `memReq` drops after 4 BUSY cycles, `memDataOut=32'hDEADBEEF`, `memErr=1` held until reset. Without the macro, stall persists for 300 cycles and `memErr` stays 0.
